// File: rtl/stack_ctrl_if.sv
// Command, SB and stack-memory signals of the stack sequencer.
// The slave side is the sequencer; the master side is the control unit plus memory.
interface stack_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_len;
  logic [23:0] push_data;
  logic [7:0]  sb_data;
  logic        sb_bus_enable;
  logic [7:0]  sb_out;
  logic [7:0]  s_out;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [23:0] pull_data;
  logic        done;

  modport master (
    output cmd_valid, cmd_op, cmd_len, push_data, sb_data, sb_bus_enable,
           mem_rdata, mem_ack,
    input  cmd_ready, sb_out, s_out, mem_req, mem_we, mem_addr, mem_wdata,
           pull_data, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, push_data, sb_data, sb_bus_enable,
           mem_rdata, mem_ack,
    output cmd_ready, sb_out, s_out, mem_req, mem_we, mem_addr, mem_wdata,
           pull_data, done
  );
endinterface

// File: rtl/stack_ctrl.sv
// 6502 stack-access sequencer: owns S and turns PUSH/PULL/LOAD_S commands
// into byte-wise bus cycles at {STACK_PAGE, S}.
//
// state | meaning
// IDLE  | ready for a command
// PUSH  | writing byte k at {page,S}, S decrements on each ack
// PULL  | reading byte k at {page,S+1}, S increments on each ack
// FIN   | done pulse, results final
module stack_ctrl #(
  parameter logic [7:0] STACK_PAGE = 8'h01,
  parameter logic [7:0] S_RESET    = 8'hFD
) (
  input logic        clk,
  input logic        rst,
  stack_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PUSH, PULL, FIN} state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_PUSH  = 2'b01;
  localparam logic [1:0] OP_PULL  = 2'b10;
  localparam logic [1:0] OP_LOADS = 2'b11;

  state_t      state;
  logic [7:0]  s;
  logic [1:0]  len;
  logic [1:0]  k;
  logic [23:0] push_buf;
  logic [23:0] pull_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        done;

  logic [1:0]  cmd_len_eff;
  logic        ack;
  logic        last;

  function automatic logic [7:0] byte_sel(input logic [23:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      default: b = w[23:16];
    endcase
    return b;
  endfunction

  assign cmd_len_eff = (bus.cmd_len == 2'd0) ? 2'd1 : bus.cmd_len;
  assign ack         = mem_req && bus.mem_ack;
  assign last        = ((k + 2'd1) == len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s         <= S_RESET;
      len       <= 2'd1;
      k         <= 2'd0;
      push_buf  <= 24'h0;
      pull_data <= 24'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0;
      mem_wdata <= 8'h0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            len      <= cmd_len_eff;
            push_buf <= bus.push_data;
            k        <= 2'd0;
            case (bus.cmd_op)
              OP_NOP: begin
                state <= FIN;
                done  <= 1'b1;
              end
              OP_LOADS: begin
                s     <= bus.sb_data;
                state <= FIN;
                done  <= 1'b1;
              end
              OP_PUSH: begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {STACK_PAGE, s};
                mem_wdata <= bus.push_data[7:0];
                state     <= PUSH;
              end
              default: begin
                pull_data <= 24'h0;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= {STACK_PAGE, s + 8'd1};
                state     <= PULL;
              end
            endcase
          end
        end

        PUSH: begin
          if (ack) begin
            s <= s - 8'd1;
            k <= k + 2'd1;
            if (last) begin
              mem_req <= 1'b0;
              state   <= FIN;
              done    <= 1'b1;
            end else begin
              mem_addr  <= {STACK_PAGE, s - 8'd1};
              mem_wdata <= byte_sel(push_buf, k + 2'd1);
            end
          end
        end

        PULL: begin
          if (ack) begin
            s <= s + 8'd1;
            k <= k + 2'd1;
            case (k)
              2'd0:    pull_data[7:0]   <= bus.mem_rdata;
              2'd1:    pull_data[15:8]  <= bus.mem_rdata;
              default: pull_data[23:16] <= bus.mem_rdata;
            endcase
            if (last) begin
              mem_req <= 1'b0;
              state   <= FIN;
              done    <= 1'b1;
            end else begin
              // next read sits one above the S that this ack produces
              mem_addr <= {STACK_PAGE, s + 8'd2};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state == IDLE) && !rst;
  assign bus.s_out     = s;
  assign bus.sb_out    = bus.sb_bus_enable ? s : 8'h00;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.pull_data = pull_data;
  assign bus.done      = done;

endmodule
